feature_mem_seq: RTL and testbench
==================================

Name: feature_mem_seq

Overview:
Sequencer for the Tn-group scratchpad feature memory. It loads feature lines from the input bus into the memory, writing either a full Tn x KERNEL_SIZE window or a single sliding line. It then issues the KERNEL_SIZE line reads toward the compute array in oldest-to-newest order. It tracks a circular head-line pointer so that line-buffer sliding needs no data movement.

Parameters:
Tn, `Tn (default 4), number of memory groups; legal range 1..16.
KERNEL_SIZE, `KERNEL_SIZE (default 3), lines per group; legal range 1..16.
DATA_BUS_WIDTH, `DATA_BUS_WIDTH, width of one input beat.
WR_LAT, 2, cycles from this block's last wr_en until the memory content is readable.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  pulse; begin an operation; sampled only in IDLE
mode  in  1  sampled with start; 0 = full load, 1 = single-line update
in_data  in  DATA_BUS_WIDTH  input beat
in_valid  in  1  in_data valid
in_ready  out  1  beat accepted when in_valid & in_ready
wr_en  out  1  memory write strobe
wr_mem_group  out  4  target group
wr_mem_line  out  4  target line
wr_data  out  DATA_BUS_WIDTH  write data
rd_en  out  1  memory read strobe
rd_mem_line  out  4  line being read
out_ready  in  1  consumer can take a read line
head_line  out  4  index of the oldest line
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at operation end

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0: in_ready, wr_en, wr_mem_group, wr_mem_line, wr_data, rd_en, rd_mem_line, head_line, busy, done. Internal counters 0. A reset mid-operation aborts it; no done pulse is generated.
- States: IDLE, LOAD, WAIT, READ, DONE.
- IDLE:
  - start=1 with mode=0: clear grp_cnt and line_cnt, set head_line=0, go to LOAD.
  - start=1 with mode=1: clear grp_cnt, set line_cnt=head_line, go to LOAD.
  - start while not in IDLE is ignored.
- LOAD:
  - in_ready = (state==LOAD), decoded from the state register.
  - Per accepted beat at edge t, registered at t+1: wr_en=1, wr_mem_group=grp_cnt, wr_mem_line=line_cnt, wr_data=in_data. With no accepted beat, wr_en=0 and wr_data=0.
  - Full-load order: line_cnt increments first and wraps at KERNEL_SIZE-1 -> 0, then grp_cnt increments. Total Tn*KERNEL_SIZE beats.
  - Update order: line_cnt is fixed; grp_cnt steps 0..Tn-1. Total Tn beats.
  - On the last accepted beat: go to WAIT and load wait_cnt=WR_LAT. In update mode only, head_line <= (head_line+1) mod KERNEL_SIZE; head_line=KERNEL_SIZE-1 wraps to 0.
  - in_valid low stalls with no timeout.
- WAIT: decrement wait_cnt each cycle; go to READ when it reaches 0 (WR_LAT=0 goes straight to READ). Guarantees the first rd_en is at least WR_LAT+1 cycles after the last wr_en.
- READ:
  - For each cycle with out_ready=1, the next cycle has rd_en=1 and rd_mem_line=(head_line+rd_cnt) mod KERNEL_SIZE; rd_cnt then increments.
  - out_ready=0 gives rd_en=0 and holds rd_cnt.
  - After KERNEL_SIZE issues, go to DONE.
  - Reads cover all Tn groups in parallel, so no group index is driven.
- DONE: done=1 for exactly one cycle, then IDLE. busy stays 1 through DONE.
- mode=1 is legal before any full load: it writes line 0 and advances head_line.
- All arithmetic is modulo KERNEL_SIZE, never 16. Counters are 4 bits.

Test Plan:
- Tn=4, K=3. Reset, then start with mode=0 and 12 back-to-back beats D0..D11 -> wr_en is high for 12 cycles, (group,line) runs (0,0),(0,1),(0,2),(1,0)..(3,2), and wr_data=Dn one cycle after each accept. After WAIT, rd_en is high for 3 cycles with lines 0,1,2. done pulses once; head_line=0.
- After the full load, start with mode=1 and 4 beats -> writes go to (0..3, line 0) and head_line becomes 1. Reads follow lines 1,2,0.
- Three consecutive updates from head_line=2 -> write lines 2,0,1; head_line ends at 2 (wrap 2->0 checked).
- in_valid toggled 1,0,1,0 during LOAD -> wr_en fires only on accepted beats; beat count and addresses stay exact. out_ready low for 2 cycles mid-READ -> rd_en gaps, no lines skipped or repeated.
- Last beat accepted at cycle t with WR_LAT=2 -> last wr_en at t+1, first rd_en no earlier than t+4. A start pulse during LOAD is ignored.
- rst driven low asynchronously mid-LOAD (between clock edges) -> all outputs are 0 immediately, head_line=0, and no done pulse occurs; a subsequent mode=0 operation completes normally.

Source files
------------

// File: rtl/feature_mem_seq.sv
// feature_mem_seq: load/slide sequencer for the Tn-group scratchpad feature memory
module feature_mem_seq #(
  parameter int Tn             = 4,
  parameter int KERNEL_SIZE    = 3,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int WR_LAT         = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,
  input  logic [DATA_BUS_WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      wr_en,
  output logic [3:0]                wr_mem_group,
  output logic [3:0]                wr_mem_line,
  output logic [DATA_BUS_WIDTH-1:0] wr_data,
  output logic                      rd_en,
  output logic [3:0]                rd_mem_line,
  input  logic                      out_ready,
  output logic [3:0]                head_line,
  output logic                      busy,
  output logic                      done
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] READ = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic [3:0] G_LAST = 4'(Tn - 1);
  localparam logic [3:0] K_LAST = 4'(KERNEL_SIZE - 1);
  logic [2:0] state;
  logic       mode_r;
  logic [3:0] grp_cnt, line_cnt, rd_cnt, wait_cnt;
  logic       accept, last_beat;
  logic [4:0] rd_sum;
  logic [3:0] rd_line, head_next;
  assign in_ready = state == LOAD;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  // beat handshake, last-beat detect and modulo-KERNEL_SIZE line arithmetic
  always_comb begin
    accept    = in_valid & in_ready;
    last_beat = accept && grp_cnt == G_LAST && (mode_r || line_cnt == K_LAST);
    rd_sum    = {1'b0, head_line} + {1'b0, rd_cnt};
    rd_line   = rd_sum >= 5'(KERNEL_SIZE) ? 4'(rd_sum - 5'(KERNEL_SIZE)) : rd_sum[3:0];
    head_next = head_line == K_LAST ? 4'd0 : head_line + 4'd1;
  end
  // register accepted beats onto the memory write port one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en        <= 1'b0;
      wr_data      <= '0;
      wr_mem_group <= 4'd0;
      wr_mem_line  <= 4'd0;
    end else begin
      wr_en   <= accept;
      wr_data <= accept ? in_data : '0;
      if (accept) begin
        wr_mem_group <= grp_cnt;
        wr_mem_line  <= line_cnt;
      end
    end
  end
  // issue one line read per cycle the consumer is ready, oldest line first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en       <= 1'b0;
      rd_mem_line <= 4'd0;
    end else begin
      rd_en <= state == READ && out_ready;
      if (state == READ && out_ready) rd_mem_line <= rd_line;
    end
  end
  // operation FSM with write/read counters and circular head pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mode_r    <= 1'b0;
      grp_cnt   <= 4'd0;
      line_cnt  <= 4'd0;
      rd_cnt    <= 4'd0;
      wait_cnt  <= 4'd0;
      head_line <= 4'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= LOAD;
          mode_r   <= mode;
          grp_cnt  <= 4'd0;
          rd_cnt   <= 4'd0;
          line_cnt <= mode ? head_line : 4'd0;
          if (!mode) head_line <= 4'd0;
        end
        LOAD: if (accept) begin
          if (last_beat) begin
            state    <= WR_LAT == 0 ? READ : WAIT;
            wait_cnt <= 4'(WR_LAT);
            if (mode_r) head_line <= head_next;
          end else if (mode_r || line_cnt == K_LAST) begin
            grp_cnt <= grp_cnt + 4'd1;
            if (!mode_r) line_cnt <= 4'd0;
          end else begin
            line_cnt <= line_cnt + 4'd1;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) state <= READ;
        end
        READ: if (out_ready) begin
          rd_cnt <= rd_cnt + 4'd1;
          if (rd_cnt == K_LAST) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_feature_mem_seq.sv
// tb_feature_mem_seq: directed table-driven bench for feature_mem_seq
module tb_feature_mem_seq;
  localparam int TN = 4;
  localparam int K  = 3;
  localparam int DW = 16;
  logic          clk = 0, rst = 0, start = 0, mode = 0, in_valid = 0, out_ready = 1;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, wr_en, rd_en, busy, done;
  logic [3:0]    wr_mem_group, wr_mem_line, rd_mem_line, head_line;
  logic [DW-1:0] wr_data;
  int cyc = 0, passed = 0, total = 0, donecnt = 0;
  typedef struct {logic [3:0] g; logic [3:0] l; logic [DW-1:0] d; int c;} wr_t;
  typedef struct {logic [3:0] l; int c;} rd_t;
  typedef struct {
    logic mode; logic toggle; logic stall;
    logic [3:0] wline; logic [3:0] head; logic [3:0] rd0; logic [3:0] rd1; logic [3:0] rd2;
  } vec_t;
  wr_t wq[$];
  rd_t rq[$];
  vec_t vecs[8];

  feature_mem_seq #(.Tn(TN), .KERNEL_SIZE(K), .DATA_BUS_WIDTH(DW), .WR_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_mem_group(wr_mem_group),
    .wr_mem_line(wr_mem_line), .wr_data(wr_data), .rd_en(rd_en), .rd_mem_line(rd_mem_line),
    .out_ready(out_ready), .head_line(head_line), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wr_en) wq.push_back(wr_t'{wr_mem_group, wr_mem_line, wr_data, cyc});
    if (rd_en) rq.push_back(rd_t'{rd_mem_line, cyc});
    if (done) donecnt <= donecnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_op(input vec_t v, input int base);
    int n, i, lc, t, d0;
    logic [3:0] er[3];
    n = v.mode ? TN : TN * K;
    er[0] = v.rd0; er[1] = v.rd1; er[2] = v.rd2;
    wq.delete(); rq.delete();
    d0 = donecnt;
    @(negedge clk); start = 1; mode = v.mode;
    @(negedge clk); start = 0;
    i = 0; lc = 0;
    while (i < n && lc < 200) begin
      @(negedge clk); lc++;
      start = v.toggle && lc == 2;
      if (v.toggle && lc % 2 == 0) in_valid = 0;
      else begin
        in_valid = 1; in_data = DW'(base + i);
        if (in_ready) i++;
      end
    end
    check("beats_accepted", i, n);
    @(negedge clk); in_valid = 0; start = 0;
    if (v.stall) begin
      t = 0;
      while (!rd_en && t < 50) begin @(negedge clk); t++; end
      out_ready = 0;
      @(negedge clk); @(negedge clk);
      out_ready = 1;
    end
    t = 0;
    while (!done && t < 100) begin @(negedge clk); t++; end
    check("done_seen", done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after", busy, 0);
    @(negedge clk);
    check("done_count", donecnt - d0, 1);
    check("head_line", head_line, v.head);
    check("wr_count", wq.size(), n);
    for (int j = 0; j < wq.size() && j < n; j++) begin
      check("wr_group", wq[j].g, v.mode ? j : j / K);
      check("wr_line", wq[j].l, v.mode ? v.wline : j % K);
      check("wr_data", wq[j].d, base + j);
    end
    if (wq.size() == n) check("wr_span", wq[n-1].c - wq[0].c, v.toggle ? 2 * (n - 1) : n - 1);
    check("rd_count", rq.size(), K);
    for (int j = 0; j < rq.size() && j < K; j++) check("rd_line", rq[j].l, er[j]);
    if (rq.size() == K) check("rd_span", rq[K-1].c - rq[0].c, v.stall ? 4 : 2);
    if (rq.size() > 0 && wq.size() > 0) check("wr_to_rd_gap", (rq[0].c - wq[wq.size()-1].c) >= 3, 1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 4'd2, 4'd0, 4'd1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0, 4'd1, 4'd2};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 4'd1, 4'd2, 4'd2, 4'd0, 4'd1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd0};
    #2;
    check("rst_ctrl", {in_ready, wr_en, rd_en, busy, done}, 0);
    check("rst_addr", {wr_mem_group, wr_mem_line, rd_mem_line, head_line}, 0);
    check("rst_wdata", wr_data, 0);
    @(negedge clk); @(negedge clk); rst = 1;
    for (int k = 0; k < 8; k++) run_op(vecs[k], 16'h100 * (k + 1));
    begin
      int d0;
      d0 = donecnt;
      @(negedge clk); start = 1; mode = 1;
      @(negedge clk); start = 0; in_valid = 1; in_data = 16'hBEEF;
      @(negedge clk); @(negedge clk);
      check("mid_load_busy", busy, 1);
      @(posedge clk); #3 rst = 0;
      #1;
      check("arst_ctrl", {in_ready, wr_en, rd_en, busy, done}, 0);
      check("arst_addr", {wr_mem_group, wr_mem_line, rd_mem_line, head_line}, 0);
      check("arst_wdata", wr_data, 0);
      in_valid = 0;
      @(negedge clk); @(negedge clk); rst = 1;
      repeat (6) @(negedge clk);
      check("arst_no_done", donecnt - d0, 0);
      check("arst_idle", busy, 0);
    end
    run_op(vecs[0], 16'h900);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
